// File: rtl/reset_sequencer.sv
// Multi-domain power-up reset sequencer: holds all domains in reset, then releases them in index order.
// Optional macro RSEQ_READY_MONITOR_EN: in RUN, a required domain losing ready for 2 cycles takes the timeout path.
module reset_sequencer #(
    parameter int unsigned             NUM_DOMAINS    = 3,
    parameter int unsigned             POWERUP_CYCLES = 33554432,
    parameter int unsigned             STAGE_GAP      = 16,
    parameter logic [NUM_DOMAINS-1:0]  READY_REQUIRED = NUM_DOMAINS'(1),
    parameter int unsigned             READY_TIMEOUT  = 1048576,
    parameter int unsigned             MAX_RETRIES    = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   manual_reset,
    input  logic [NUM_DOMAINS-1:0] domain_ready,
    output logic [NUM_DOMAINS-1:0] domain_resetn,
    output logic                   all_released,
    output logic                   busy,
    output logic                   fault,
    output logic [2:0]             fault_domain,
    output logic [3:0]             retry_count
);

    localparam int unsigned HW = $clog2(POWERUP_CYCLES + 1);
    localparam int unsigned WW = $clog2(READY_TIMEOUT + 1);
    localparam int unsigned GW = $clog2(STAGE_GAP + 1);
    localparam int unsigned IW = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    typedef enum logic [2:0] {
        S_HOLD  = 3'd0,
        S_WAIT  = 3'd1,
        S_GAP   = 3'd2,
        S_RUN   = 3'd3,
        S_FAULT = 3'd4
    } state_e;

    state_e                 state_q, state_d;
    logic [HW-1:0]          hold_cnt_q, hold_cnt_d;
    logic [WW-1:0]          wait_cnt_q, wait_cnt_d;
    logic [GW-1:0]          gap_cnt_q, gap_cnt_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [NUM_DOMAINS-1:0] resetn_q, resetn_d;
    logic                   all_rel_q, all_rel_d;
    logic                   busy_q, busy_d;
    logic                   fault_q, fault_d;
    logic [2:0]             fault_dom_q, fault_dom_d;
    logic [3:0]             retry_q, retry_d;
    logic                   mr_meta_q, mr_sync_q;
    logic                   timeout_c;
    logic [IW-1:0]          to_idx_c;
`ifdef RSEQ_READY_MONITOR_EN
    logic [NUM_DOMAINS-1:0] low_q, low_d;
`endif

    // Two-flop synchroniser for the asynchronous manual reset request
    always_ff @(posedge clk) begin
        if (!reset) begin
            mr_meta_q <= 1'b0;
            mr_sync_q <= 1'b0;
        end else begin
            mr_meta_q <= manual_reset;
            mr_sync_q <= mr_meta_q;
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_HOLD;
            hold_cnt_q  <= '0;
            wait_cnt_q  <= '0;
            gap_cnt_q   <= '0;
            idx_q       <= '0;
            resetn_q    <= '0;
            all_rel_q   <= 1'b0;
            busy_q      <= 1'b1;
            fault_q     <= 1'b0;
            fault_dom_q <= '0;
            retry_q     <= '0;
`ifdef RSEQ_READY_MONITOR_EN
            low_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            idx_q       <= idx_d;
            resetn_q    <= resetn_d;
            all_rel_q   <= all_rel_d;
            busy_q      <= busy_d;
            fault_q     <= fault_d;
            fault_dom_q <= fault_dom_d;
            retry_q     <= retry_d;
`ifdef RSEQ_READY_MONITOR_EN
            low_q       <= low_d;
`endif
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        idx_d       = idx_q;
        resetn_d    = resetn_q;
        fault_d     = fault_q;
        fault_dom_d = fault_dom_q;
        retry_d     = retry_q;
        timeout_c   = 1'b0;
        to_idx_c    = idx_q;
`ifdef RSEQ_READY_MONITOR_EN
        low_d       = '0;
`endif

        unique case (state_q)
            S_HOLD: begin
                if (hold_cnt_q == HW'(POWERUP_CYCLES - 1)) begin
                    state_d     = S_WAIT;
                    resetn_d[0] = 1'b1;
                    idx_d       = '0;
                    wait_cnt_d  = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + HW'(1);
                end
            end
            S_WAIT: begin
                // A ready arriving on the final waiting cycle takes priority over the timeout
                if (!READY_REQUIRED[idx_q] || domain_ready[idx_q]) begin
                    state_d   = S_GAP;
                    gap_cnt_d = '0;
                end else if (wait_cnt_q == WW'(READY_TIMEOUT - 1)) begin
                    timeout_c = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WW'(1);
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GW'(STAGE_GAP - 1)) begin
                    if (idx_q == IW'(NUM_DOMAINS - 1)) begin
                        state_d = S_RUN;
                    end else begin
                        idx_d                      = idx_q + IW'(1);
                        resetn_d[idx_q + IW'(1)]   = 1'b1;
                        wait_cnt_d                 = '0;
                        state_d                    = S_WAIT;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                end
            end
            S_RUN: begin
`ifdef RSEQ_READY_MONITOR_EN
                low_d = READY_REQUIRED & ~domain_ready;
                for (int i = int'(NUM_DOMAINS) - 1; i >= 0; i--) begin
                    if (low_d[i] && low_q[i]) begin
                        timeout_c = 1'b1;
                        to_idx_c  = IW'(i);
                    end
                end
`endif
            end
            S_FAULT: begin
            end
            default: state_d = S_HOLD;
        endcase

        if (timeout_c) begin
            resetn_d   = '0;
            hold_cnt_d = '0;
            wait_cnt_d = '0;
            gap_cnt_d  = '0;
            idx_d      = '0;
            if (retry_q < 4'(MAX_RETRIES)) begin
                retry_d = retry_q + 4'd1;
                state_d = S_HOLD;
            end else begin
                state_d     = S_FAULT;
                fault_d     = 1'b1;
                fault_dom_d = 3'(to_idx_c);
            end
        end

        // Synchronised manual reset overrides everything, including FAULT
        if (mr_sync_q) begin
            state_d     = S_HOLD;
            hold_cnt_d  = '0;
            wait_cnt_d  = '0;
            gap_cnt_d   = '0;
            idx_d       = '0;
            resetn_d    = '0;
            fault_d     = 1'b0;
            fault_dom_d = '0;
            retry_d     = '0;
`ifdef RSEQ_READY_MONITOR_EN
            low_d       = '0;
`endif
        end

        busy_d    = (state_d == S_HOLD) || (state_d == S_WAIT) || (state_d == S_GAP);
        all_rel_d = (state_d == S_RUN);
    end

    assign domain_resetn = resetn_q;
    assign all_released  = all_rel_q;
    assign busy          = busy_q;
    assign fault         = fault_q;
    assign fault_domain  = fault_dom_q;
    assign retry_count   = retry_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: an event-timeline model predicts every output per edge.
module tb_reset_sequencer;

    localparam int unsigned ND  = 3;
    localparam int unsigned P   = 8;
    localparam int unsigned G   = 2;
    localparam logic [ND-1:0] REQ = 3'b010;
    localparam int unsigned TO  = 16;
    localparam int unsigned MR  = 1;
    localparam int MAXE  = 100;
    localparam int NEVER = 100000;

    logic          clk = 1'b0;
    logic          reset;
    logic          manual_reset;
    logic [ND-1:0] domain_ready;
    logic [ND-1:0] domain_resetn;
    logic          all_released;
    logic          busy;
    logic          fault;
    logic [2:0]    fault_domain;
    logic [3:0]    retry_count;

    int errors = 0;
    int checks = 0;
    logic [12:0] exp_v [0:MAXE];
    int rdy_at [ND];

    reset_sequencer #(
        .NUM_DOMAINS    (ND),
        .POWERUP_CYCLES (P),
        .STAGE_GAP      (G),
        .READY_REQUIRED (REQ),
        .READY_TIMEOUT  (TO),
        .MAX_RETRIES    (MR)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .manual_reset  (manual_reset),
        .domain_ready  (domain_ready),
        .domain_resetn (domain_resetn),
        .all_released  (all_released),
        .busy          (busy),
        .fault         (fault),
        .fault_domain  (fault_domain),
        .retry_count   (retry_count)
    );

    always #5 clk = ~clk;

    function automatic logic [12:0] pack(input logic [ND-1:0] rn, input logic b, input logic a,
                                         input logic f, input logic [2:0] fd, input logic [3:0] rc);
        return {rn, b, a, f, fd, rc};
    endfunction

    function automatic logic [12:0] observed();
        return pack(domain_resetn, busy, all_released, fault, fault_domain, retry_count);
    endfunction

    task automatic set_from(input int e, input logic [12:0] v);
        for (int k = e; k <= MAXE; k++) exp_v[k] = v;
    endtask

    // Timeline model: pass start, release edges, ready arrivals and deadlines as plain arithmetic
    task automatic build_expect();
        int s, t, w, done, deadline, retry, fd;
        logic [ND-1:0] rn;
        bit timed_out, finished;
        s = 1; retry = 0; fd = 0; deadline = 0; finished = 0;
        set_from(0, pack('0, 1'b1, 1'b0, 1'b0, 3'd0, 4'd0));
        while (!finished) begin
            t = s + int'(P) - 1;
            rn = '0;
            rn[0] = 1'b1;
            set_from(t, pack(rn, 1'b1, 1'b0, 1'b0, 3'd0, 4'(retry)));
            timed_out = 0;
            for (int d = 0; d < int'(ND); d++) begin
                w = t + 1;
                done = w;
                if (REQ[d]) begin
                    deadline = w + int'(TO) - 1;
                    done = (rdy_at[d] > w) ? rdy_at[d] : w;
                    if (done > deadline) begin
                        timed_out = 1;
                        fd = d;
                        break;
                    end
                end
                t = done + int'(G);
                if (d == int'(ND) - 1) begin
                    set_from(t, pack(rn, 1'b0, 1'b1, 1'b0, 3'd0, 4'(retry)));
                end else begin
                    rn[d+1] = 1'b1;
                    set_from(t, pack(rn, 1'b1, 1'b0, 1'b0, 3'd0, 4'(retry)));
                end
            end
            if (!timed_out) begin
                finished = 1;
            end else if (retry < int'(MR)) begin
                retry++;
                set_from(deadline, pack('0, 1'b1, 1'b0, 1'b0, 3'd0, 4'(retry)));
                s = deadline + 1;
            end else begin
                set_from(deadline, pack('0, 1'b0, 1'b0, 1'b1, 3'(fd), 4'(retry)));
                finished = 1;
            end
        end
    endtask

    task automatic drive_ready(input int n);
        for (int i = 0; i < int'(ND); i++)
            domain_ready[i] = REQ[i] ? (n >= rdy_at[i]) : 1'($urandom_range(0, 1));
    endtask

    task automatic check_now(input string name, input int n, input logic [12:0] want);
        logic [12:0] got;
        got = observed();
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s edge %0d: got %b required %b (rn,busy,all,fault,fd,retry)", name, n, got, want);
        end
    endtask

    task automatic run_edges(input int n_from, input int n_to, input string name);
        for (int n = n_from; n <= n_to; n++) begin
            drive_ready(n);
            @(posedge clk); #1;
            check_now(name, n, exp_v[n]);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive_ready(0);
        @(posedge clk); #1;
        check_now("reset_state", 0, pack('0, 1'b1, 1'b0, 1'b0, 3'd0, 4'd0));
        reset = 1'b1;
    endtask

    task automatic test_sequence(input int rdy1, input string name);
        rdy_at = '{0, rdy1, 0};
        build_expect();
        test_reset();
        run_edges(1, 70, name);
    endtask

    task automatic test_manual_reset();
        logic [12:0] fault_v, reset_v;
        test_sequence(NEVER, "fault_pass");
        fault_v = pack('0, 1'b0, 1'b0, 1'b1, 3'd1, 4'd1);
        reset_v = pack('0, 1'b1, 1'b0, 1'b0, 3'd0, 4'd0);
        rdy_at = '{0, 0, 0};
        build_expect();
        for (int k = 1; k <= 5; k++) begin
            manual_reset = (k <= 3);
            domain_ready = '1;
            @(posedge clk); #1;
            check_now("manual_sync", k, (k <= 2) ? fault_v : reset_v);
        end
        run_edges(1, 20, "manual_restart");
    endtask

    task automatic test_reset_mid_gap();
        rdy_at = '{0, 0, 0};
        build_expect();
        test_reset();
        run_edges(1, 12, "pre_gap_reset");
        reset = 1'b0;
        @(posedge clk); #1;
        check_now("mid_gap_reset", 13, pack('0, 1'b1, 1'b0, 1'b0, 3'd0, 4'd0));
        reset = 1'b1;
        run_edges(1, 20, "after_gap_reset");
    endtask

    task automatic test_ready_monitor();
        logic [12:0] run_v, want;
        rdy_at = '{0, 0, 0};
        build_expect();
        test_reset();
        run_edges(1, 20, "monitor_lead");
        run_v = pack('1, 1'b0, 1'b1, 1'b0, 3'd0, 4'd0);
        for (int n = 21; n <= 27; n++) begin
            domain_ready = '1;
            domain_ready[1] = !(n == 21 || n == 25 || n == 26);
            @(posedge clk); #1;
            want = run_v;
`ifdef RSEQ_READY_MONITOR_EN
            if (n >= 26) want = pack('0, 1'b1, 1'b0, 1'b0, 3'd0, 4'd1);
`endif
            check_now("run_ready_drop", n, want);
        end
    endtask

    initial begin
        reset        = 1'b0;
        manual_reset = 1'b0;
        domain_ready = '0;
        rdy_at       = '{0, 0, 0};
        test_reset();
        test_sequence(0, "all_ready");
        test_sequence(21, "late_ready");
        test_sequence(27, "ready_at_deadline");
        test_sequence(28, "ready_after_deadline");
        test_sequence(54, "ready_at_second_deadline");
        test_sequence(55, "ready_too_late");
        for (int r = 0; r < 6; r++) test_sequence(int'($urandom_range(0, 60)), "random_ready");
        test_manual_reset();
        test_reset_mid_gap();
        test_ready_monitor();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
